uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter. Serialises one word per frame onto tx: start bit,
//  5..9 data bits (LSB or MSB first), optional even/odd parity, 1 or 2 stop bits.
//  Bit timing comes from an external one-cycle baud_tick strobe. Words arrive over a
//  valid/ready handshake, and a one-cycle done pulse marks the end of each frame.
//  Sits between the SoC register/FIFO layer and the pad; baud generator is external.
// PARAMETERS
//  DATA_BITS  8  data bits per frame, legal 5..9 (elaboration error otherwise)
//  PARITY     0  0 = none, 1 = even, 2 = odd (encodings from uart_pkg)
//  STOP_BITS  1  stop bits per frame, legal 1 or 2
//  MSB_FIRST  0  0 = data bit 0 sent first, 1 = bit DATA_BITS-1 sent first
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  baud_tick  in   1          one-clk strobe, one per bit period
//  in_valid   in   1          in_data holds a word to send
//  in_ready   out  1          block can accept a word this cycle
//  in_data    in   DATA_BITS  word to transmit
//  tx         out  1          serial line, idle high
//  busy       out  1          a frame is in progress (accepted, not yet complete)
//  tx_done    out  1          one-clk pulse when the frame completes
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): tx=1, busy=0, in_ready=1, tx_done=0, state=IDLE.
//   Reset overrides everything, including mid-frame: the line returns high next cycle
//   and the partial frame is abandoned (no tx_done).
//  Frame length N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
//  Registered outputs: tx, busy and tx_done come from flops. in_ready = (state==IDLE).
//  Accept: handshake completes on a posedge with in_valid && in_ready. in_data is
//   captured into a DATA_BITS shift register. Parity is computed from the captured
//   word (even: XOR of bits; odd: inverted XOR). busy=1 and in_ready=0 from the next
//   cycle. A baud_tick in the accept cycle is ignored.
//  States: IDLE -> WAIT -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   Every state other than IDLE advances only on a clock where baud_tick=1.
//   - WAIT: the next tick drives tx=0 and enters START.
//   - START: the next tick drives the first data bit and enters DATA.
//   - DATA: each tick shifts out the next bit under a bit counter. The tick after the
//     last data bit drives parity (PARITY!=0) or tx=1 (stop bit).
//   - PARITY: the next tick drives tx=1 and enters STOP.
//   - STOP: tx holds 1 for STOP_BITS tick periods. The tick ending the last stop period
//     gives state=IDLE, busy=0, in_ready=1 and tx_done=1 for exactly one clock.
//  Latency: tx falls at the posedge of the first baud_tick after acceptance. Each bit is
//   held exactly one tick period. tx_done comes N tick periods after tx falls.
//  Back-to-back: a word can be accepted in the cycle after tx_done. Its start bit begins
//   at the following tick, so the line stays high for at least one extra period.
//  baud_tick high on consecutive clocks: each tick counts; no filtering.
//  in_valid is ignored while busy, and in_data may change freely after acceptance.
//  tx_done and rst together: rst wins and tx_done=0.
//  Bit counter width: $clog2(DATA_BITS+1). The stop counter is 1 bit.
// STRUCTURE
//  uart_pkg (shared): state_t enum {IDLE,WAIT,START,DATA,PARITY,STOP}, PARITY_NONE/
//   EVEN/ODD localparams, and the parity function par_bit(word, mode).
//  A single always_ff FSM with inline shift register and counters; no sub-module.
//  The existing baud generator stays outside and drives baud_tick.
// TESTING  (the bench samples tx on each baud_tick; the frame is decoded by a reference UART model)
//  8N1, LSB-first, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, then tx_done=1 for 1 clk,
//   in_ready=1.
//  8E1 0xA5 -> parity bit 0. 8O2 0xA5 -> parity 1 and two stop bits. 7O1 0x41 -> parity 1.
//  MSB_FIRST=1, 8N1, 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 (mirror of the data bits).
//  baud_tick asserted in the accept cycle -> tx stays 1 until the next tick.
//   in_valid held for 3 words -> exactly 3 frames and 3 tx_done pulses.
//  rst pulsed during data bit 4 of 0xFF -> tx=1, busy=0, in_ready=1 next cycle, no
//   tx_done. The next word 0x00 is sent intact.
//  9N1 0x1FF and 5N1 0x15 -> correct frame length N=11 and N=7 tick periods.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// parity helper used when a word is captured.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic par_bit(input logic [8:0] word, input int mode);
        if (mode == PARITY_NONE) return 1'b0;
        if (mode == PARITY_ODD)  return ~(^word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, 5..9 data bits, optional parity,
// 1 or 2 stop bits, paced by an external one-cycle baud_tick strobe.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, shreg_shift;
    logic [CW-1:0]        bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par, par_n;
    logic                 tx_n, busy_n, done_n;
    logic                 head;

    // The head of the shift register is always the next data bit to go out.
    assign head        = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];
    assign shreg_shift = (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], 1'b0}
                                          : {1'b0, shreg[DATA_BITS-1:1]};
    assign in_ready    = (state == IDLE);

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                // A tick landing in the accept cycle is deliberately not used.
                if (in_valid) begin
                    shreg_n = in_data;
                    par_n   = par_bit(9'(in_data), PARITY);
                    busy_n  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (baud_tick) begin
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_n      = head;
                    shreg_n   = shreg_shift;
                    bit_cnt_n = CW'(1);
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY != PARITY_NONE) begin
                            tx_n    = par;
                            state_n = uart_pkg::PARITY;
                        end else begin
                            tx_n       = 1'b1;
                            stop_cnt_n = 1'b0;
                            state_n    = STOP;
                        end
                    end else begin
                        tx_n      = head;
                        shreg_n   = shreg_shift;
                        bit_cnt_n = bit_cnt + CW'(1);
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (baud_tick) begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par      <= par_n;
            tx       <= tx_n;
            busy     <= busy_n;
            tx_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: seven configurations side by side, each checked every
// cycle against a frame-list model, plus literal frame expectations.
module tb_uart_tx_cfg;

    localparam int NC = 7;
    // 8N1, 8E1, 8O2, 7O1, 8N1 MSB-first, 9N1, 5N1
    localparam int DB [NC] = '{8, 8, 8, 7, 8, 9, 5};
    localparam int PAR[NC] = '{0, 1, 2, 2, 0, 0, 0};
    localparam int SB [NC] = '{1, 1, 2, 1, 1, 1, 1};
    localparam int MF [NC] = '{0, 0, 0, 0, 1, 0, 0};

    logic [8:0]  words    [NC] = '{9'h0A5, 9'h0A5, 9'h0A5, 9'h041, 9'h0A5, 9'h1FF, 9'h015};
    logic [15:0] exp_line [NC] = '{16'h034A, 16'h054A, 16'h0F4A, 16'h0382, 16'h034A, 16'h07FE, 16'h006A};
    int          exp_len  [NC] = '{10, 11, 12, 10, 10, 11, 7};

    logic clk = 1'b0, rst = 1'b1, baud_tick = 1'b0;
    logic [NC-1:0] in_valid = '0;
    logic [NC-1:0] in_ready, tx, busy, tx_done;
    logic [8:0]    in_data [NC];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        uart_tx_cfg #(.DATA_BITS(DB[g]), .PARITY(PAR[g]), .STOP_BITS(SB[g]), .MSB_FIRST(MF[g])) dut (
            .clk      (clk),
            .rst      (rst),
            .baud_tick(baud_tick),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g][DB[g]-1:0]),
            .tx       (tx[g]),
            .busy     (busy[g]),
            .tx_done  (tx_done[g])
        );
    end

    int checks = 0, errors = 0;

    // Model: a frame is a list of line levels; each tick advances one entry,
    // and the tick after the last entry ends the frame.
    bit          m_busy  [NC];
    int          m_phase [NC];
    int          m_len   [NC];
    logic [15:0] m_frame [NC];
    logic        m_tx    [NC];
    logic        m_done  [NC];
    bit          lg      [NC];
    logic [15:0] log_v   [NC];
    int          acc_cnt [NC];
    int          done_cnt[NC];

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, g, $time, act, exp);
        end
    endtask

    function automatic void build_frame(input int g, input logic [8:0] w, output logic [15:0] f, output int n);
        int ones = 0;
        f = '0;
        n = 1;
        for (int i = 0; i < DB[g]; i++) begin
            f[n] = w[(MF[g] != 0) ? DB[g] - 1 - i : i];
            n++;
        end
        if (PAR[g] != 0) begin
            for (int i = 0; i < DB[g]; i++) ones += int'(w[i]);
            f[n] = ((ones % 2) == 1) ^ (PAR[g] == 2);
            n++;
        end
        for (int s = 0; s < SB[g]; s++) begin
            f[n] = 1'b1;
            n++;
        end
    endfunction

    function automatic bit any_busy();
        for (int g = 0; g < NC; g++) if (m_busy[g]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < NC; g++) begin
            lg[g] = 1'b0;
            m_done[g] = 1'b0;
            if (rst) begin
                m_busy[g] = 1'b0;
                m_tx[g]   = 1'b1;
            end else if (!m_busy[g]) begin
                if (in_valid[g]) begin
                    build_frame(g, in_data[g], m_frame[g], m_len[g]);
                    m_busy[g]  = 1'b1;
                    m_phase[g] = -1;
                    log_v[g]   = '0;
                    acc_cnt[g]++;
                end
            end else if (baud_tick) begin
                m_phase[g]++;
                if (m_phase[g] < m_len[g]) begin
                    m_tx[g] = m_frame[g][m_phase[g]];
                    lg[g]   = 1'b1;
                end else begin
                    m_busy[g] = 1'b0;
                    m_done[g] = 1'b1;
                    m_tx[g]   = 1'b1;
                end
            end
        end
        #1;
        for (int g = 0; g < NC; g++) begin
            check("tx", g, tx[g], m_tx[g]);
            check("busy", g, busy[g], m_busy[g]);
            check("in_ready", g, in_ready[g], !m_busy[g]);
            check("tx_done", g, tx_done[g], m_done[g]);
            if (tx_done[g] === 1'b1) done_cnt[g]++;
            if (lg[g]) log_v[g][m_phase[g]] = tx[g];
        end
    end

    task automatic wait_idle(input int period, input int budget);
        int c = 0;
        while (any_busy() && c < budget) begin
            baud_tick = (c % period) == 0;
            @(negedge clk);
            c++;
        end
        baud_tick = 1'b0;
        check("idle_timeout", 0, any_busy(), 0);
    endtask

    initial begin
        logic [15:0] f;
        int n, dc, a0, c;
        for (int g = 0; g < NC; g++) begin
            in_data[g] = '0; m_busy[g] = 1'b0; m_tx[g] = 1'b1; m_phase[g] = 0; m_len[g] = 0;
            m_frame[g] = '0; log_v[g] = '0; acc_cnt[g] = 0; done_cnt[g] = 0; m_done[g] = 1'b0;
        end
        // Pin the model against hand-computed frames.
        for (int g = 0; g < NC; g++) begin
            build_frame(g, words[g], f, n);
            check("model_frame", g, f, exp_line[g]);
            check("model_len", g, n, exp_len[g]);
        end
        repeat (3) @(negedge clk);
        check("reset_tx", 0, tx[0], 1);
        check("reset_ready", 0, in_ready[0], 1);
        rst = 1'b0;

        // Directed frames; the tick in the accept cycle must not start the frame.
        @(negedge clk);
        in_valid = '1;
        for (int g = 0; g < NC; g++) in_data[g] = words[g];
        baud_tick = 1'b1;
        @(negedge clk);
        in_valid = '0;
        baud_tick = 1'b0;
        check("tx_hold_after_accept", 0, tx[0], 1);
        wait_idle(4, 600);
        for (int g = 0; g < NC; g++) begin
            check("line_bits", g, log_v[g], exp_line[g]);
            check("done_count", g, done_cnt[g], 1);
        end

        // Reset in the middle of data bit 4 of an all-ones word.
        @(negedge clk);
        in_valid = '1;
        for (int g = 0; g < NC; g++) in_data[g] = 9'h1FF;
        @(negedge clk);
        in_valid = '0;
        c = 0;
        while (m_phase[0] != 5 && c < 200) begin
            baud_tick = (c % 3) == 0;
            @(negedge clk);
            c++;
        end
        baud_tick = 1'b0;
        check("reach_bit4", 0, m_phase[0], 5);
        dc = done_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", 0, tx[0], 1);
        check("rst_mid_busy", 0, busy[0], 0);
        check("rst_mid_ready", 0, in_ready[0], 1);
        @(negedge clk);
        in_valid = '1;
        for (int g = 0; g < NC; g++) in_data[g] = 9'h000;
        @(negedge clk);
        in_valid = '0;
        wait_idle(2, 600);
        check("after_rst_line", 0, log_v[0], 16'h0200);
        check("after_rst_done", 0, done_cnt[0], dc + 1);

        // in_valid held high for three words on the 8N1 instance.
        dc = done_cnt[0];
        a0 = acc_cnt[0];
        c = 0;
        in_valid[0] = 1'b1;
        while (acc_cnt[0] - a0 < 3 && c < 400) begin
            in_data[0] = 9'($urandom);
            baud_tick = (c % 2) == 0;
            @(negedge clk);
            c++;
        end
        in_valid[0] = 1'b0;
        wait_idle(2, 400);
        check("three_accepts", 0, acc_cnt[0] - a0, 3);
        check("three_dones", 0, done_cnt[0] - dc, 3);

        // Random traffic: sparse and back-to-back ticks, random words, rare resets.
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 599) == 0;
            baud_tick = (i % 500 < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            for (int g = 0; g < NC; g++) begin
                in_valid[g] = $urandom_range(0, 1) == 1;
                in_data[g]  = 9'($urandom);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = '0;
        wait_idle(1, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
